// File: rtl/tone_arbiter_pkg.sv
// Shared widths, default timing and arbiter state encoding for the tone-path arbiter.
// Imported by the interface, the tick generator and the arbiter top.
package tone_arbiter_pkg;

    localparam int NUM_SFX_DEF  = 4;
    localparam int FREQ_W_DEF   = 16;
    localparam int VOL_W_DEF    = 7;
    localparam int TICK_DIV_DEF = 500000;
    localparam int LEN_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/tone_arbiter_if.sv
// Bundle between the sequencers/effect requesters and the arbiter, plus the arbiter's audio-path outputs.
// master = requester/sequencer side, slave = arbiter side.
interface tone_arbiter_if
    import tone_arbiter_pkg::*;
#(
    parameter int NUM_SFX = NUM_SFX_DEF,
    parameter int FREQ_W  = FREQ_W_DEF,
    parameter int VOL_W   = VOL_W_DEF
);
    logic [FREQ_W-1:0]         bgm_freq;
    logic [VOL_W-1:0]          bgm_vol;
    logic [NUM_SFX-1:0]        sfx_req;
    logic [NUM_SFX*FREQ_W-1:0] sfx_freq;
    logic [NUM_SFX*LEN_W-1:0]  sfx_len;
    logic                      mute;
    logic [NUM_SFX-1:0]        sfx_gnt;
    logic [NUM_SFX-1:0]        sfx_done;
    logic                      busy;
    logic [FREQ_W-1:0]         out_freq;
    logic [VOL_W-1:0]          out_vol;
    logic                      vol_update;

    modport master (
        output bgm_freq, bgm_vol, sfx_req, sfx_freq, sfx_len, mute,
        input  sfx_gnt, sfx_done, busy, out_freq, out_vol, vol_update
    );

    modport slave (
        input  bgm_freq, bgm_vol, sfx_req, sfx_freq, sfx_len, mute,
        output sfx_gnt, sfx_done, busy, out_freq, out_vol, vol_update
    );

endinterface

// File: rtl/tone_arbiter_note_tick_gen.sv
// Free-running note tick: one-cycle pulse every TICK_DIV clocks; clr restarts the period.
// Tick is decoded from the registered count; no backpressure.
module note_tick_gen
    import tone_arbiter_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int               CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tone_arbiter.sv
// Shares the tone/volume path between BGM and fixed-priority one-shot effects; all outputs registered.
// Requests latch into pending and wait (no preemption); grants occur only from IDLE or after an effect's GAP.
module tone_arbiter
    import tone_arbiter_pkg::*;
#(
    parameter int NUM_SFX  = NUM_SFX_DEF,
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int VOL_W    = VOL_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst,
    tone_arbiter_if.slave  bus
);
    arb_state_e         state_q, state_d;
    logic [NUM_SFX-1:0] pending_q, pending_d;
    logic [NUM_SFX-1:0] sel_oh_q, sel_oh_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [NUM_SFX-1:0] gnt_q, gnt_d;
    logic [NUM_SFX-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [FREQ_W-1:0]  raw_freq_q, raw_freq_d;
    logic [FREQ_W-1:0]  out_freq_q, out_freq_d;
    logic [VOL_W-1:0]   out_vol_q, out_vol_d;
    logic [VOL_W-1:0]   vol_prev_q;
    logic               vol_update_q;

    logic [NUM_SFX-1:0] sel_oh;
    logic [FREQ_W-1:0]  sel_freq;
    logic [LEN_W-1:0]   sel_len;
    logic               tick;
    logic               tick_clr;

    note_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Descending scan so the lowest pending index is the last (winning) assignment.
    always_comb begin
        sel_oh   = '0;
        sel_freq = '0;
        sel_len  = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_freq  = bus.sfx_freq[i*FREQ_W +: FREQ_W];
                sel_len   = bus.sfx_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | bus.sfx_req;
        sel_oh_d   = sel_oh_q;
        freq_d     = freq_q;
        len_d      = len_q;
        gnt_d      = '0;
        done_d     = '0;
        tick_clr   = 1'b0;
        raw_freq_d = raw_freq_q;

        case (state_q)
            ST_IDLE: begin
                raw_freq_d = bus.bgm_freq;
                if (pending_q != '0) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A request for the granted index in this same cycle re-arms it for one replay.
                pending_d = (pending_q & ~sel_oh) | bus.sfx_req;
                sel_oh_d  = sel_oh;
                freq_d    = sel_freq;
                len_d     = sel_len;
                gnt_d     = sel_oh;
                tick_clr  = 1'b1;
                state_d   = (sel_len == '0) ? ST_DONE : ST_PLAY;
            end
            ST_PLAY: begin
                raw_freq_d = freq_q;
                if (tick) begin
                    if (len_q != '0) begin
                        len_d = len_q - LEN_W'(1);
                    end
                    if (len_q <= LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                raw_freq_d = '0;
                done_d     = sel_oh_q;
                tick_clr   = 1'b1;
                state_d    = ST_GAP;
            end
            ST_GAP: begin
                raw_freq_d = '0;
                if (tick) begin
                    state_d = (pending_q != '0) ? ST_GRANT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_freq_d = bus.mute ? '0 : raw_freq_d;
        out_vol_d  = bus.mute ? '0 : bus.bgm_vol;
        busy_d     = (state_d != ST_IDLE) || (pending_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            sel_oh_q     <= '0;
            freq_q       <= '0;
            len_q        <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            raw_freq_q   <= '0;
            out_freq_q   <= '0;
            out_vol_q    <= '0;
            vol_prev_q   <= '0;
            vol_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            sel_oh_q     <= sel_oh_d;
            freq_q       <= freq_d;
            len_q        <= len_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            raw_freq_q   <= raw_freq_d;
            out_freq_q   <= out_freq_d;
            out_vol_q    <= out_vol_d;
            vol_prev_q   <= out_vol_q;
            vol_update_q <= (out_vol_q != vol_prev_q);
        end
    end

    assign bus.sfx_gnt    = gnt_q;
    assign bus.sfx_done   = done_q;
    assign bus.busy       = busy_q;
    assign bus.out_freq   = out_freq_q;
    assign bus.out_vol    = out_vol_q;
    assign bus.vol_update = vol_update_q;

endmodule
